// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide, stalling the pipeline until the result is ready.
module ex_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t              state_reg;
  logic [2:0]          op_reg;
  logic                neg_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [XLEN-1:0]     mcand_reg;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod_reg;
  logic [XLEN-1:0]     rem_reg;
  logic [XLEN-1:0]     quo_reg;
  logic                done_reg;
  logic [XLEN-1:0]     result_reg;

  // Operand decode for the instruction presented in EX
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg_res, div_zero, div_ovf;
  logic [XLEN-1:0] special_val;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sign_a   = a_signed & rs1_data[XLEN-1];
  assign sign_b   = b_signed & rs2_data[XLEN-1];
  assign mag_a    = sign_a ? -rs1_data : rs1_data;
  assign mag_b    = sign_b ? -rs2_data : rs2_data;

  always_comb begin
    neg_res = 1'b0;
    case (op)
      OP_MUL, OP_MULH: neg_res = sign_a ^ sign_b;
      OP_MULHSU:       neg_res = sign_a;
      OP_DIV:          neg_res = (sign_a ^ sign_b) & (rs2_data != '0);
      OP_REM:          neg_res = sign_a;
      default:         neg_res = 1'b0;
    endcase
  end

  assign div_zero = op[2] & (rs2_data == '0);
  assign div_ovf  = op[2] & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
  // Overflow quotient is rs1 itself (the most negative value); overflow remainder is 0
  assign special_val = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);

  // One multiply step: conditional add into the upper half, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, mcand_reg};
  assign mul_next = prod_reg[0] ? {mul_sum, prod_reg[XLEN-1:1]} : {1'b0, prod_reg[2*XLEN-1:1]};

  // One restoring-divide step; the kept difference is always below the divisor
  logic [XLEN:0]   rem_sh;
  logic            div_ok;
  logic [XLEN-1:0] rem_sub;
  assign rem_sh  = {rem_reg, quo_reg[XLEN-1]};
  assign div_ok  = rem_sh >= {1'b0, mcand_reg};
  assign rem_sub = rem_sh[XLEN-1:0] - mcand_reg;

  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, sign_val;
  assign prod_fin = neg_reg ? -prod_reg : prod_reg;
  assign quo_fin  = neg_reg ? -quo_reg : quo_reg;
  assign rem_fin  = neg_reg ? -rem_reg : rem_reg;

  always_comb begin
    sign_val = '0;
    case (op_reg)
      OP_MUL:                     sign_val = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sign_val = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            sign_val = quo_fin;
      default:                    sign_val = rem_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              op_reg    <= op;
              neg_reg   <= neg_res;
              cnt_reg   <= '0;
              mcand_reg <= op[2] ? mag_b : mag_a;
              prod_reg  <= {{XLEN{1'b0}}, mag_b};
              rem_reg   <= '0;
              quo_reg   <= mag_a;
              if (div_zero || div_ovf) begin
                result_reg <= special_val;
                done_reg   <= 1'b1;
                state_reg  <= DONE;
              end else begin
                state_reg <= CALC;
              end
            end
          end
          CALC: begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (op_reg[2]) begin
              rem_reg <= div_ok ? rem_sub : rem_sh[XLEN-1:0];
              quo_reg <= {quo_reg[XLEN-2:0], div_ok};
            end else begin
              prod_reg <= mul_next;
            end
            if (cnt_reg == CNT_W'(XLEN-1)) state_reg <= SIGN;
          end
          SIGN: begin
            result_reg <= sign_val;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
          DONE: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign stall  = ~rst & ~flush &
                  (((state_reg == IDLE) & start) | (state_reg == CALC) | (state_reg == SIGN));
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed and random RV32M operations checked
// against an arithmetic reference model, plus flush and reset scenarios.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int fails  = 0;

  ex_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics computed with plain integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      p;
    logic [63:0] pv;
    logic [31:0] r;
    ia = a;
    ib = b;
    r  = '0;
    case (o)
      3'd0: r = a * b;
      3'd1: begin p = longint'(ia) * longint'(ib); pv = p; r = pv[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'b0, b}); pv = p; r = pv[63:32]; end
      3'd3: begin pv = {32'b0, a} * {32'b0, b}; r = pv[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = ia / ib;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one operation in the current cycle and follow it to completion
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          exp_lat, lat, stall_cycles;
    bit          got;
    exp     = model(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : 34;
    op = o; rs1_data = a; rs2_data = b; start = 1'b1;
    #1;
    check({tag, " stall_at_start"}, 32'(stall), 32'd1);
    lat = 0; got = 1'b0; stall_cycles = 0;
    while (!got && lat < 200) begin
      if (stall) stall_cycles++;
      tick();
      start    = 1'b0;
      op       = 3'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall_in_done"}, 32'(stall), 32'd0);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, a, b, result, exp, lat);
    tick();
    check({tag, " done_pulse_end"}, 32'(done), 32'd0);
    check({tag, " result_held"}, result, exp);
  endtask

  initial begin
    int pulses;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b1; flush = 1'b0;
    op = 3'b101; rs1_data = 32'd5; rs2_data = 32'd0;
    #2;
    check("reset_stall", 32'(stall), 32'd0);
    tick(); tick();
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall_held", 32'(stall), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("post_reset_done", 32'(done), 32'd0);
    check("post_reset_stall", 32'(stall), 32'd0);

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(3'b011, 32'h8000_0000, 32'h8000_0000, "mulhu_min");
    run_op(3'b010, 32'h8000_0000, 32'h8000_0000, "mulhsu_min");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, "divu_-7/2");
    run_op(3'b100, 32'd9, 32'd0, "div_by_zero");
    run_op(3'b111, 32'd5, 32'd0, "remu_by_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");

    // Flush mid-CALC, then restart two cycles later
    op = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 1'b0;
      check("flush_wait_no_done", 32'(done), 32'd0);
    end
    flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_no_done", 32'(done), 32'd0);
    check("flush_idle_stall", 32'(stall), 32'd0);
    tick();
    run_op(3'b101, 32'd100, 32'd7, "divu_after_flush");

    // Reset mid-operation; start while reset is held must be ignored
    op = 3'b000; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; start = 1'b1;
    #1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; start = 1'b1; op = 3'b101; rs2_data = 32'd0;
    #1;
    check("midreset_stall", 32'(stall), 32'd0);
    tick();
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_stall_held", 32'(stall), 32'd0);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("midreset_no_late_done", 32'(pulses), 32'd0);
    check("midreset_result_kept", result, 32'd0);

    // Random operations with biased operand corners
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
